// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA configuration-load path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cgra_pkg;

  // Configuration-loader FSM states, exported on conf_loader.state_o.
  typedef enum logic [1:0] {
    S_CONF_IDLE,
    S_CONF_FETCH,
    S_CONF_DRAIN,
    S_CONF_DONE
  } conf_fsm_t;

  // Bytes per configuration word; the bus address advances by this per request.
  localparam int CONF_WORD_BYTES = 4;

endpackage : cgra_pkg

// File: rtl/conf_loader.sv
// Configuration fetch controller: streams a block of 32-bit words from memory into the
// fabric's configuration registers, indexed 0..n-1, and flags start/completion.
// Latency: req_o one cycle after an accepted start; cfg_we_o one cycle after each rvalid_i.
// Backpressure: req_o/addr_o held until gnt_i; no new request once MAX_OUTST are unanswered.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   start_i, base_addr_i, size_i         load request (sampled in S_CONF_IDLE only)
//   req_o, addr_o, gnt_i                 read-request channel of the bus master port
//   rvalid_i, rdata_i                    in-order read responses
//   cfg_we_o, cfg_idx_o, cfg_data_o      configuration register write port
//   conf_change_o, conf_done_o           start-accepted / load-complete pulses
//   busy_o, state_o                      status
module conf_loader
  import cgra_pkg::*;
#(
  parameter int  N_CFG_WORDS = 64,
  parameter int  MAX_OUTST   = 2,
  parameter int  SIZE_W      = 16,
  localparam int IDX_W       = $clog2(N_CFG_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              req_o,
  output logic [31:0]       addr_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  output logic              cfg_we_o,
  output logic [IDX_W-1:0]  cfg_idx_o,
  output logic [31:0]       cfg_data_o,
  output logic              conf_change_o,
  output logic              conf_done_o,
  output logic              busy_o,
  output conf_fsm_t         state_o
);

  // Word counters must hold the value N_CFG_WORDS itself, hence the +1.
  localparam int CNT_W = $clog2(N_CFG_WORDS + 1);
  // Outstanding counter sized for MAX_OUTST up to 4.
  localparam int OUT_W = 3;

  localparam logic [SIZE_W-1:0] N_WORDS_SZ  = SIZE_W'(N_CFG_WORDS);
  localparam logic [CNT_W-1:0]  N_WORDS_CNT = CNT_W'(N_CFG_WORDS);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [OUT_W-1:0]  OUT_ONE     = OUT_W'(1);
  localparam logic [OUT_W-1:0]  MAX_OUT     = OUT_W'(MAX_OUTST);
  localparam logic [31:0]       ADDR_STEP   = 32'(CONF_WORD_BYTES);

  conf_fsm_t          state_q, state_d;
  logic [CNT_W-1:0]   n_words_q, n_words_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [31:0]        addr_q, addr_d;
  logic               cfg_we_q, cfg_we_d;
  logic [IDX_W-1:0]   cfg_idx_q, cfg_idx_d;
  logic [31:0]        cfg_data_q, cfg_data_d;

  logic               req;
  logic               grant;
  logic               rsp_acc;
  logic [CNT_W-1:0]   size_clamped;
  logic [CNT_W-1:0]   req_cnt_inc;
  logic [CNT_W-1:0]   rsp_cnt_inc;

  // Request is decoded from registered state only, so gnt_i/rvalid_i never reach req_o
  // combinationally; the window reopens the cycle after a response lowers outst_q.
  assign req     = (state_q == S_CONF_FETCH) && (outst_q < MAX_OUT);
  assign grant   = req && gnt_i;
  // Responses only count while a load is on the bus. A response with nothing
  // outstanding cannot belong to this load and would underflow outst_q, so it is dropped.
  assign rsp_acc = rvalid_i && (outst_q != '0) &&
                   ((state_q == S_CONF_FETCH) || (state_q == S_CONF_DRAIN));

  assign size_clamped = (size_i > N_WORDS_SZ) ? N_WORDS_CNT : size_i[CNT_W-1:0];
  assign req_cnt_inc  = req_cnt_q + CNT_ONE;
  assign rsp_cnt_inc  = rsp_cnt_q + CNT_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_CONF_IDLE;
      n_words_q  <= '0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      outst_q    <= '0;
      addr_q     <= '0;
      cfg_we_q   <= 1'b0;
      cfg_idx_q  <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_words_q  <= n_words_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      outst_q    <= outst_d;
      addr_q     <= addr_d;
      cfg_we_q   <= cfg_we_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_words_d  = n_words_q;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    outst_d    = outst_q;
    addr_d     = addr_q;
    cfg_we_d   = 1'b0;
    cfg_idx_d  = cfg_idx_q;
    cfg_data_d = cfg_data_q;

    case (state_q)
      S_CONF_IDLE: begin
        if (start_i) begin
          n_words_d = size_clamped;
          addr_d    = base_addr_i & ~32'h3;
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          outst_d   = '0;
          state_d   = (size_clamped == '0) ? S_CONF_DONE : S_CONF_FETCH;
        end
      end
      S_CONF_FETCH: begin
        if (grant) begin
          addr_d    = addr_q + ADDR_STEP;
          req_cnt_d = req_cnt_inc;
          if (req_cnt_inc == n_words_q) begin
            state_d = S_CONF_DRAIN;
          end
        end
      end
      S_CONF_DRAIN: begin
        // The last response always arrives here: it cannot precede its own grant,
        // and that grant is what leaves FETCH.
        if (rsp_acc && (rsp_cnt_inc == n_words_q)) begin
          state_d = S_CONF_DONE;
        end
      end
      S_CONF_DONE: begin
        state_d = S_CONF_IDLE;
      end
      default: begin
        state_d = S_CONF_IDLE;
      end
    endcase

    // Response register: one write per accepted response, index taken before increment.
    if (rsp_acc) begin
      cfg_we_d   = 1'b1;
      cfg_idx_d  = rsp_cnt_q[IDX_W-1:0];
      cfg_data_d = rdata_i;
      rsp_cnt_d  = rsp_cnt_inc;
    end

    // Grant and response in the same cycle cancel out.
    case ({grant, rsp_acc})
      2'b10:   outst_d = outst_q + OUT_ONE;
      2'b01:   outst_d = outst_q - OUT_ONE;
      default: outst_d = outst_q;
    endcase
  end

  assign req_o      = req;
  assign addr_o     = addr_q;
  assign cfg_we_o   = cfg_we_q;
  assign cfg_idx_o  = cfg_idx_q;
  assign cfg_data_o = cfg_data_q;
  assign busy_o     = (state_q != S_CONF_IDLE);
  assign state_o    = state_q;
  assign conf_done_o = (state_q == S_CONF_DONE);
  // Acknowledges the start in the request cycle itself, so a zero-size load shows
  // conf_change_o and then conf_done_o on consecutive cycles.
  assign conf_change_o = start_i && (state_q == S_CONF_IDLE);

endmodule : conf_loader

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader with a pipelined memory responder model.
// Latency: responses return a programmable number of cycles after each grant.
// Backpressure: grants can be withheld on a chosen address for a chosen number of cycles.
module tb_conf_loader;
  import cgra_pkg::*;

  localparam int N  = 64;
  localparam int MO = 2;
  localparam int SW = 16;
  localparam int IW = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic [31:0]   base_addr_i = '0;
  logic [SW-1:0] size_i = '0;
  logic          req_o;
  logic [31:0]   addr_o;
  logic          gnt_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic [31:0]   rdata_i = '0;
  logic          cfg_we_o;
  logic [IW-1:0] cfg_idx_o;
  logic [31:0]   cfg_data_o;
  logic          conf_change_o;
  logic          conf_done_o;
  logic          busy_o;
  conf_fsm_t     state_o;

  conf_loader #(.N_CFG_WORDS(N), .MAX_OUTST(MO), .SIZE_W(SW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .size_i(size_i), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .cfg_we_o(cfg_we_o), .cfg_idx_o(cfg_idx_o),
    .cfg_data_o(cfg_data_o), .conf_change_o(conf_change_o), .conf_done_o(conf_done_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  // Bus model and observation log.
  int            cyc = 0;
  int            lat = 1;
  logic [31:0]   deny_addr = 32'h1;
  int            deny_left = 0;
  logic          stray_rv = 1'b0;
  logic [31:0]   pend_addr[$];
  int            pend_due[$];
  logic [31:0]   g_addr[$];
  logic [IW-1:0] w_idx[$];
  logic [31:0]   w_dat[$];
  int            change_cyc, change_cnt, done_cyc, done_cnt;
  logic          done_we;
  logic [IW-1:0] done_idx;
  int            req_cycles, hold_cnt, outst_m, outst_max;
  logic          tr_req [0:4095];
  logic          tr_busy[0:4095];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Each cycle at negedge+2: log DUT outputs, then drive this cycle's response and grant.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      cyc++;
      tr_req[cyc % 4096]  = req_o;
      tr_busy[cyc % 4096] = busy_o;
      if (req_o) req_cycles++;
      if (req_o && addr_o == deny_addr) hold_cnt++;
      if (cfg_we_o) begin
        w_idx.push_back(cfg_idx_o);
        w_dat.push_back(cfg_data_o);
      end
      if (conf_change_o) begin
        change_cyc = cyc;
        change_cnt++;
      end
      if (conf_done_o) begin
        done_cyc = cyc;
        done_cnt++;
        done_we  = cfg_we_o;
        done_idx = cfg_idx_o;
      end
      rvalid_i = 1'b0;
      rdata_i  = '0;
      if (stray_rv) begin
        rvalid_i = 1'b1;
        rdata_i  = 32'hBAD0_BAD0;
        stray_rv = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        rvalid_i = 1'b1;
        rdata_i  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        outst_m--;
      end
      gnt_i = 1'b1;
      if (req_o && addr_o == deny_addr && deny_left > 0) begin
        gnt_i = 1'b0;
        deny_left--;
      end
      if (req_o && gnt_i) begin
        g_addr.push_back(addr_o);
        pend_addr.push_back(addr_o);
        pend_due.push_back(cyc + lat);
        outst_m++;
      end
      if (outst_m > outst_max) outst_max = outst_m;
    end
  end

  task automatic clear_logs();
    g_addr.delete(); w_idx.delete(); w_dat.delete();
    pend_addr.delete(); pend_due.delete();
    change_cyc = -1; change_cnt = 0; done_cyc = -1; done_cnt = 0;
    done_we = 1'b0; done_idx = '0;
    req_cycles = 0; hold_cnt = 0; outst_m = 0; outst_max = 0;
  endtask

  // Issues one start pulse (optionally a second one restart_after cycles into the load)
  // and waits, bounded, for conf_done_o. c0 is the cycle in which start_i was high.
  task automatic run_load(input logic [31:0] base, input logic [SW-1:0] size, input int l,
                          input int restart_after, output int c0, output bit ok);
    lat = l;
    clear_logs();
    @(negedge clk_i); #1;
    base_addr_i = base; size_i = size; start_i = 1'b1;
    c0 = cyc + 1;
    @(negedge clk_i); #1;
    start_i = 1'b0; base_addr_i = 32'hDEAD_BEEF; size_i = SW'(7);
    if (restart_after > 0) begin
      repeat (restart_after) begin @(negedge clk_i); #1; end
      base_addr_i = 32'h0000_9000; size_i = SW'(1); start_i = 1'b1;
      @(negedge clk_i); #1;
      start_i = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i); #3;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++; if (req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", req_o); else passed++;
    total++; if (addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", addr_o); else passed++;
    total++; if (cfg_we_o !== 1'b0) $display("FAIL rst_we: got %b want 0", cfg_we_o); else passed++;
    total++; if (cfg_idx_o !== '0 || cfg_data_o !== 32'h0)
      $display("FAIL rst_cfg: got idx %h data %h want 0/0", cfg_idx_o, cfg_data_o); else passed++;
    total++; if (conf_done_o !== 1'b0 || conf_change_o !== 1'b0)
      $display("FAIL rst_pulses: got done %b change %b want 0/0", conf_done_o, conf_change_o); else passed++;
    total++; if (busy_o !== 1'b0 || state_o !== S_CONF_IDLE)
      $display("FAIL rst_state: got busy %b state %0d want 0/IDLE", busy_o, state_o); else passed++;
    @(negedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    total++; if (busy_o !== 1'b0 || req_o !== 1'b0)
      $display("FAIL idle_after_rst: got busy %b req %b want 0/0", busy_o, req_o); else passed++;
  endtask

  task automatic test_basic();
    int c0; bit ok;
    run_load(32'h0000_1000, SW'(4), 1, 0, c0, ok);
    total++; if (!ok) $display("FAIL basic_timeout: got no conf_done want conf_done"); else passed++;
    total++; if (change_cyc !== c0) $display("FAIL basic_change: got cyc %0d want %0d", change_cyc, c0); else passed++;
    total++; if (tr_req[c0 % 4096] !== 1'b0 || tr_req[(c0 + 1) % 4096] !== 1'b1)
      $display("FAIL basic_first_req: got %b%b want 01", tr_req[c0 % 4096], tr_req[(c0 + 1) % 4096]); else passed++;
    total++; if (g_addr.size() != 4) $display("FAIL basic_ngrant: got %0d want 4", g_addr.size()); else passed++;
    for (int i = 0; i < g_addr.size() && i < 4; i++) begin
      total++; if (g_addr[i] !== 32'h1000 + 32'(4 * i))
        $display("FAIL basic_addr%0d: got %h want %h", i, g_addr[i], 32'h1000 + 32'(4 * i)); else passed++;
    end
    total++; if (w_idx.size() != 4) $display("FAIL basic_nwr: got %0d want 4", w_idx.size()); else passed++;
    for (int i = 0; i < w_idx.size() && i < 4; i++) begin
      total++; if (w_idx[i] !== IW'(i) || w_dat[i] !== mem_word(32'h1000 + 32'(4 * i)))
        $display("FAIL basic_wr%0d: got idx %0d data %h want idx %0d data %h", i, w_idx[i], w_dat[i],
                 i, mem_word(32'h1000 + 32'(4 * i))); else passed++;
    end
    total++; if (done_cyc - c0 != 6) $display("FAIL basic_done_lat: got %0d want 6", done_cyc - c0); else passed++;
    total++; if (done_we !== 1'b1 || done_idx !== IW'(3))
      $display("FAIL basic_done_with_last: got we %b idx %0d want 1/3", done_we, done_idx); else passed++;
    total++; if (tr_busy[done_cyc % 4096] !== 1'b1 || tr_busy[(done_cyc + 1) % 4096] !== 1'b0)
      $display("FAIL basic_busy_drop: got %b%b want 10", tr_busy[done_cyc % 4096],
               tr_busy[(done_cyc + 1) % 4096]); else passed++;
  endtask

  task automatic test_outstanding();
    int c0; bit ok;
    logic exp_req[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_load(32'h0000_2000, SW'(4), 5, 0, c0, ok);
    total++; if (!ok) $display("FAIL outst_timeout: got no conf_done want conf_done"); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++; if (tr_req[(c0 + i) % 4096] !== exp_req[i])
        $display("FAIL outst_req_c%0d: got %b want %b", i, tr_req[(c0 + i) % 4096], exp_req[i]); else passed++;
    end
    total++; if (outst_max != 2) $display("FAIL outst_max: got %0d want 2", outst_max); else passed++;
    total++; if (done_cyc - c0 != 14) $display("FAIL outst_done_lat: got %0d want 14", done_cyc - c0); else passed++;
    total++; if (w_idx.size() != 4 || w_idx[3] !== IW'(3) || w_dat[3] !== mem_word(32'h200C))
      $display("FAIL outst_writes: got n %0d want 4 ending idx 3 data %h", w_idx.size(), mem_word(32'h200C)); else passed++;
  endtask

  task automatic test_gnt_hold();
    int c0; bit ok;
    deny_addr = 32'h0000_1004;
    deny_left = 3;
    run_load(32'h0000_1000, SW'(4), 1, 0, c0, ok);
    total++; if (!ok) $display("FAIL hold_timeout: got no conf_done want conf_done"); else passed++;
    total++; if (hold_cnt != 4) $display("FAIL hold_req_addr: got %0d cycles want 4", hold_cnt); else passed++;
    total++; if (g_addr.size() != 4) $display("FAIL hold_ngrant: got %0d want 4", g_addr.size()); else passed++;
    for (int i = 0; i < g_addr.size() && i < 4; i++) begin
      total++; if (g_addr[i] !== 32'h1000 + 32'(4 * i))
        $display("FAIL hold_addr%0d: got %h want %h", i, g_addr[i], 32'h1000 + 32'(4 * i)); else passed++;
    end
    total++; if (w_idx.size() != 4) $display("FAIL hold_nwr: got %0d want 4", w_idx.size()); else passed++;
    for (int i = 0; i < w_idx.size() && i < 4; i++) begin
      total++; if (w_idx[i] !== IW'(i) || w_dat[i] !== mem_word(32'h1000 + 32'(4 * i)))
        $display("FAIL hold_wr%0d: got idx %0d data %h want idx %0d", i, w_idx[i], w_dat[i], i); else passed++;
    end
    total++; if (done_cyc - c0 != 9) $display("FAIL hold_done_lat: got %0d want 9", done_cyc - c0); else passed++;
    deny_addr = 32'h1;
    deny_left = 0;
  endtask

  task automatic test_size_zero();
    int c0; bit ok;
    run_load(32'h0000_5000, SW'(0), 1, 0, c0, ok);
    total++; if (!ok) $display("FAIL zero_timeout: got no conf_done want conf_done"); else passed++;
    total++; if (change_cyc !== c0) $display("FAIL zero_change: got cyc %0d want %0d", change_cyc, c0); else passed++;
    total++; if (done_cyc !== c0 + 1) $display("FAIL zero_done: got cyc %0d want %0d", done_cyc, c0 + 1); else passed++;
    total++; if (req_cycles != 0 || g_addr.size() != 0)
      $display("FAIL zero_bus: got req cycles %0d grants %0d want 0/0", req_cycles, g_addr.size()); else passed++;
    total++; if (w_idx.size() != 0) $display("FAIL zero_writes: got %0d want 0", w_idx.size()); else passed++;
    total++; if (tr_busy[(c0 + 2) % 4096] !== 1'b0)
      $display("FAIL zero_busy: got %b want 0", tr_busy[(c0 + 2) % 4096]); else passed++;
  endtask

  task automatic test_size_clamp();
    int c0; bit ok; int bad_a; int bad_w;
    logic [31:0] a;
    run_load(32'hFFFF_FFF2, SW'(100), 1, 0, c0, ok);
    total++; if (!ok) $display("FAIL clamp_timeout: got no conf_done want conf_done"); else passed++;
    total++; if (g_addr.size() != 64 || req_cycles != 64)
      $display("FAIL clamp_nreq: got grants %0d req cycles %0d want 64/64", g_addr.size(), req_cycles); else passed++;
    total++; if (w_idx.size() != 64) $display("FAIL clamp_nwr: got %0d want 64", w_idx.size()); else passed++;
    bad_a = 0; bad_w = 0;
    for (int i = 0; i < 64; i++) begin
      a = 32'hFFFF_FFF0 + 32'(4 * i);
      if (i < g_addr.size() && g_addr[i] !== a) bad_a++;
      if (i < w_idx.size() && (w_idx[i] !== IW'(i) || w_dat[i] !== mem_word(a))) bad_w++;
    end
    total++; if (bad_a != 0) $display("FAIL clamp_wrap_addr: got %0d wrong addresses want 0", bad_a); else passed++;
    total++; if (bad_w != 0) $display("FAIL clamp_wr_seq: got %0d wrong writes want 0", bad_w); else passed++;
    total++; if (done_we !== 1'b1 || done_idx !== IW'(63))
      $display("FAIL clamp_last_idx: got we %b idx %0d want 1/63", done_we, done_idx); else passed++;
    total++; if (done_cyc - c0 != 66) $display("FAIL clamp_done_lat: got %0d want 66", done_cyc - c0); else passed++;
  endtask

  task automatic test_start_ignored();
    int c0; bit ok;
    run_load(32'h0000_3000, SW'(4), 1, 1, c0, ok);
    total++; if (!ok) $display("FAIL restart_timeout: got no conf_done want conf_done"); else passed++;
    total++; if (change_cnt != 1) $display("FAIL restart_change: got %0d pulses want 1", change_cnt); else passed++;
    total++; if (done_cnt != 1) $display("FAIL restart_done: got %0d pulses want 1", done_cnt); else passed++;
    total++; if (g_addr.size() != 4 || g_addr[0] !== 32'h3000 || g_addr[3] !== 32'h300C)
      $display("FAIL restart_addr: got n %0d want 4 from 3000 to 300C", g_addr.size()); else passed++;
    total++; if (w_idx.size() != 4 || w_idx[3] !== IW'(3) || w_dat[3] !== mem_word(32'h300C))
      $display("FAIL restart_writes: got n %0d want 4 ending idx 3", w_idx.size()); else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    clear_logs();
    lat = 5;
    @(negedge clk_i); #1;
    base_addr_i = 32'h0000_4000; size_i = SW'(8); start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i); #1;
    total++; if (busy_o !== 1'b1 || req_o !== 1'b1)
      $display("FAIL mid_pre: got busy %b req %b want 1/1", busy_o, req_o); else passed++;
    rst_ni = 1'b0;
    pend_addr.delete(); pend_due.delete(); outst_m = 0;
    #1;
    total++; if (req_o !== 1'b0 || addr_o !== 32'h0)
      $display("FAIL mid_rst_bus: got req %b addr %h want 0/0", req_o, addr_o); else passed++;
    total++; if (busy_o !== 1'b0 || state_o !== S_CONF_IDLE || conf_done_o !== 1'b0)
      $display("FAIL mid_rst_state: got busy %b state %0d done %b want 0/IDLE/0", busy_o, state_o, conf_done_o); else passed++;
    total++; if (cfg_we_o !== 1'b0 || cfg_idx_o !== '0 || cfg_data_o !== 32'h0)
      $display("FAIL mid_rst_cfg: got we %b idx %0d data %h want 0", cfg_we_o, cfg_idx_o, cfg_data_o); else passed++;
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    clear_logs();
    stray_rv = 1'b1;
    repeat (4) @(negedge clk_i);
    #3;
    total++; if (w_idx.size() != 0) $display("FAIL stray_rvalid: got %0d writes want 0", w_idx.size()); else passed++;
    total++; if (done_cnt != 0 || busy_o !== 1'b0)
      $display("FAIL stray_state: got done %0d busy %b want 0/0", done_cnt, busy_o); else passed++;
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_outstanding();
    test_gnt_hold();
    test_size_zero();
    test_size_clamp();
    test_start_ignored();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want end within 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule : tb_conf_loader
